// File: rtl/riscv_pkg.sv
// -----------------------------------------------------------------------------
// riscv_pkg
// Shared RV64 definitions: datapath/register-index widths, ALUOp encodings,
// major opcode constants and the ID/EX pipeline-register layout.
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN    = 64;  // datapath width
  localparam int REG_W   = 5;   // register-index width
  localparam int FUNCT_W = 4;   // {funct7[5], funct3}
  localparam int CNT_W   = 16;  // bubble counter width

  // ALUOp classes produced by main decode
  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,  // loads/stores: address add
    ALUOP_BRANCH = 2'b01,  // branch compare
    ALUOP_RTYPE  = 2'b10   // decode funct fields
  } aluop_e;

  // Major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;

  // Everything the EX stage needs from decode. An all-zero value is a bubble.
  typedef struct packed {
    logic               branch;
    logic               mem_read;
    logic               memto_reg;
    logic               mem_write;
    logic               alu_src;
    logic               reg_write;
    logic [1:0]         alu_op;
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    rs1_data;
    logic [XLEN-1:0]    rs2_data;
    logic [XLEN-1:0]    imm;
    logic [REG_W-1:0]   rs1;
    logic [REG_W-1:0]   rs2;
    logic [REG_W-1:0]   rd;
    logic [FUNCT_W-1:0] funct;
  } id_ex_t;

endpackage

// File: rtl/id_ex_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_stage_if
// Bundles the ID-side inputs, flush, and the registered EX-side outputs of the
// ID/EX stage.
//   slave  : the pipeline stage (consumes ID fields, produces ex_*/stall/count)
//   master : the surrounding pipeline (drives ID fields and flush)
// -----------------------------------------------------------------------------
interface id_ex_stage_if;
  import riscv_pkg::*;

  // ID stage
  logic               Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite;
  logic [1:0]         ALUOp;
  logic [XLEN-1:0]    id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [REG_W-1:0]   id_rs1, id_rs2, id_rd;
  logic [FUNCT_W-1:0] id_funct;
  logic               flush;

  // EX stage
  logic               ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc, ex_RegWrite;
  logic [1:0]         ex_ALUOp;
  logic [XLEN-1:0]    ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [REG_W-1:0]   ex_rs1, ex_rs2, ex_rd;
  logic [FUNCT_W-1:0] ex_funct;
  logic               ex_valid;
  logic               stall;
  logic [CNT_W-1:0]   bubble_count;

  modport slave (
    input  Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp,
           id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_funct, flush,
    output ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc,
           ex_RegWrite, ex_ALUOp, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct, ex_valid, stall, bubble_count
  );

  modport master (
    output Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, ALUOp,
           id_pc, id_rs1_data, id_rs2_data, id_imm, id_rs1, id_rs2, id_rd,
           id_funct, flush,
    input  ex_Branch, ex_MemRead, ex_MemtoReg, ex_MemWrite, ex_ALUSrc,
           ex_RegWrite, ex_ALUOp, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_funct, ex_valid, stall, bubble_count
  );

endinterface

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Combinational load-use detector: the instruction in EX is a valid load whose
// destination (other than x0) is a source of the instruction in ID.
//   ex_valid, ex_mem_read, ex_rd : EX-stage instruction
//   id_rs1, id_rs2               : ID-stage source indices
//   hazard                       : load-use hazard this cycle
// -----------------------------------------------------------------------------
module hazard_detect
  import riscv_pkg::*;
(
  input  logic             ex_valid,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  output logic             hazard
);

  // x0 is hard-wired zero, so a load to it never produces a dependency.
  assign hazard = ex_valid & ex_mem_read & (ex_rd != '0) &
                  ((ex_rd == id_rs1) | (ex_rd == id_rs2));

endmodule

// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
// ID/EX pipeline register with load-use bubble insertion and a saturating
// bubble counter.
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset
//   bus     : id_ex_stage_if.slave (ID inputs, flush, ex_* outputs, stall,
//             bubble_count)
// -----------------------------------------------------------------------------
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic          clk,
  input  logic          reset_n,
  id_ex_stage_if.slave  bus
);

  id_ex_t           id_d;
  id_ex_t           ex_q;
  logic             valid_q;
  logic [CNT_W-1:0] count_q;
  logic             hazard;
  logic             bubble;

  hazard_detect u_hazard_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ex_q.mem_read),
    .ex_rd       (ex_q.rd),
    .id_rs1      (bus.id_rs1),
    .id_rs2      (bus.id_rs2),
    .hazard      (hazard)
  );

  // Flush already squashes the ID instruction, so holding IF/ID would be wrong.
  assign bus.stall = hazard & ~bus.flush;
  assign bubble    = hazard | bus.flush;

  // NOTE: every field of id_d is assigned unconditionally, so no latch can form.
  always_comb begin
    id_d.branch    = bus.Branch;
    id_d.mem_read  = bus.MemRead;
    id_d.memto_reg = bus.MemtoReg;
    id_d.mem_write = bus.MemWrite;
    id_d.alu_src   = bus.ALUSrc;
    id_d.reg_write = bus.RegWrite;
    id_d.alu_op    = bus.ALUOp;
    id_d.pc        = bus.id_pc;
    id_d.rs1_data  = bus.id_rs1_data;
    id_d.rs2_data  = bus.id_rs2_data;
    id_d.imm       = bus.id_imm;
    id_d.rs1       = bus.id_rs1;
    id_d.rs2       = bus.id_rs2;
    id_d.rd        = bus.id_rd;
    id_d.funct     = bus.id_funct;
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else if (bubble) begin
      // Load constants rather than ID fields so X from decode cannot leak in.
      ex_q    <= '0;
      valid_q <= 1'b0;
      if (count_q != '1) count_q <= count_q + 1'b1;
    end else begin
      ex_q    <= id_d;
      valid_q <= 1'b1;
    end
  end

  assign bus.ex_Branch    = ex_q.branch;
  assign bus.ex_MemRead   = ex_q.mem_read;
  assign bus.ex_MemtoReg  = ex_q.memto_reg;
  assign bus.ex_MemWrite  = ex_q.mem_write;
  assign bus.ex_ALUSrc    = ex_q.alu_src;
  assign bus.ex_RegWrite  = ex_q.reg_write;
  assign bus.ex_ALUOp     = ex_q.alu_op;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_rs1_data  = ex_q.rs1_data;
  assign bus.ex_rs2_data  = ex_q.rs2_data;
  assign bus.ex_imm       = ex_q.imm;
  assign bus.ex_rs1       = ex_q.rs1;
  assign bus.ex_rs2       = ex_q.rs2;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_funct     = ex_q.funct;
  assign bus.ex_valid     = valid_q;
  assign bus.bubble_count = count_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage
// Directed bench for id_ex_stage: reset, pass-through, load-use stall, x0,
// flush over hazard, reset mid-stall and counter saturation.
// -----------------------------------------------------------------------------
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  int   total = 0;
  int   bad   = 0;

  id_ex_stage_if bus ();

  id_ex_stage dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one decoded instruction; data fields are derived from pc so each
  // instruction is distinguishable in EX.
  task automatic drive(input logic [63:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic is_load, input logic [1:0] aluop,
                       input logic [3:0] funct);
    bus.Branch      = 1'b0;
    bus.MemRead     = is_load;
    bus.MemtoReg    = is_load;
    bus.MemWrite    = 1'b0;
    bus.ALUSrc      = is_load;
    bus.RegWrite    = 1'b1;
    bus.ALUOp       = aluop;
    bus.id_pc       = pc;
    bus.id_rs1_data = pc + 64'h1000;
    bus.id_rs2_data = pc + 64'h2000;
    bus.id_imm      = is_load ? 64'd8 : 64'd0;
    bus.id_rs1      = rs1;
    bus.id_rs2      = rs2;
    bus.id_rd       = rd;
    bus.id_funct    = funct;
  endtask

  task automatic edge_sample();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n  = 1'b0;
    bus.flush = 1'b0;
    drive(64'h0, 5'd0, 5'd0, 5'd0, 1'b0, 2'b00, 4'h0);
    #12;
    check("reset_valid", bus.ex_valid, 0);
    check("reset_stall", bus.stall, 0);
    check("reset_count", bus.bubble_count, 0);

    // ---- R-type pass-through ----
    @(negedge clk);
    reset_n = 1'b1;
    drive(64'h100, 5'd1, 5'd2, 5'd5, 1'b0, 2'b10, 4'h8);
    #1 check("rtype_stall", bus.stall, 0);
    edge_sample();
    check("rtype_rd",       bus.ex_rd, 5);
    check("rtype_aluop",    bus.ex_ALUOp, 2'b10);
    check("rtype_pc",       bus.ex_pc, 64'h100);
    check("rtype_valid",    bus.ex_valid, 1);
    check("rtype_regwrite", bus.ex_RegWrite, 1);
    check("rtype_rs1_data", bus.ex_rs1_data, 64'h1100);
    check("rtype_rs2_data", bus.ex_rs2_data, 64'h2100);
    check("rtype_funct",    bus.ex_funct, 4'h8);
    check("rtype_rs2",      bus.ex_rs2, 2);

    // ---- ld x6 ; add x7, x6, x2 ----
    @(negedge clk);
    drive(64'h104, 5'd2, 5'd0, 5'd6, 1'b1, 2'b00, 4'h3);
    #1 check("ld_stall", bus.stall, 0);
    edge_sample();
    check("ld_memread", bus.ex_MemRead, 1);
    check("ld_rd",      bus.ex_rd, 6);
    check("ld_imm",     bus.ex_imm, 8);
    @(negedge clk);
    drive(64'h108, 5'd6, 5'd2, 5'd7, 1'b0, 2'b10, 4'h0);
    #1 check("lu_stall", bus.stall, 1);
    edge_sample();
    check("lu_bubble_valid",    bus.ex_valid, 0);
    check("lu_bubble_rd",       bus.ex_rd, 0);
    check("lu_bubble_regwrite", bus.ex_RegWrite, 0);
    check("lu_bubble_pc",       bus.ex_pc, 0);
    check("lu_count",           bus.bubble_count, 1);
    check("lu_stall_released",  bus.stall, 0);
    edge_sample();
    check("add_valid", bus.ex_valid, 1);
    check("add_rd",    bus.ex_rd, 7);
    check("add_pc",    bus.ex_pc, 64'h108);
    check("add_count", bus.bubble_count, 1);

    // ---- ld x0 ; use rs1 = x0 ----
    @(negedge clk);
    drive(64'h10c, 5'd3, 5'd0, 5'd0, 1'b1, 2'b00, 4'h3);
    edge_sample();
    check("ldx0_memread", bus.ex_MemRead, 1);
    @(negedge clk);
    drive(64'h110, 5'd0, 5'd0, 5'd8, 1'b0, 2'b10, 4'h0);
    #1 check("x0_stall", bus.stall, 0);
    edge_sample();
    check("x0_valid", bus.ex_valid, 1);
    check("x0_rd",    bus.ex_rd, 8);
    check("x0_count", bus.bubble_count, 1);

    // ---- ld x9 ; use rs2 = x9 with flush ----
    @(negedge clk);
    drive(64'h114, 5'd1, 5'd0, 5'd9, 1'b1, 2'b00, 4'h3);
    edge_sample();
    @(negedge clk);
    drive(64'h118, 5'd1, 5'd9, 5'd10, 1'b0, 2'b10, 4'h0);
    bus.flush = 1'b1;
    #1 check("flush_stall", bus.stall, 0);
    edge_sample();
    check("flush_valid", bus.ex_valid, 0);
    check("flush_rd",    bus.ex_rd, 0);
    check("flush_count", bus.bubble_count, 2);
    @(negedge clk);
    bus.flush = 1'b0;

    // ---- reset asserted mid-stall ----
    drive(64'h11c, 5'd1, 5'd0, 5'd11, 1'b1, 2'b00, 4'h3);
    edge_sample();
    @(negedge clk);
    drive(64'h120, 5'd11, 5'd4, 5'd12, 1'b0, 2'b10, 4'h0);
    #1 check("rst_pre_stall",    bus.stall, 1);
    check("rst_pre_regwrite",    bus.ex_RegWrite, 1);
    reset_n = 1'b0;
    #1;
    check("rst_regwrite", bus.ex_RegWrite, 0);
    check("rst_memread",  bus.ex_MemRead, 0);
    check("rst_memtoreg", bus.ex_MemtoReg, 0);
    check("rst_alusrc",   bus.ex_ALUSrc, 0);
    check("rst_rd",       bus.ex_rd, 0);
    check("rst_pc",       bus.ex_pc, 0);
    check("rst_imm",      bus.ex_imm, 0);
    check("rst_valid",    bus.ex_valid, 0);
    check("rst_count",    bus.bubble_count, 0);
    check("rst_stall",    bus.stall, 0);
    edge_sample();
    check("rst_hold_valid", bus.ex_valid, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1 check("rel_stall", bus.stall, 0);
    edge_sample();
    check("rel_valid", bus.ex_valid, 1);
    check("rel_rd",    bus.ex_rd, 12);
    check("rel_pc",    bus.ex_pc, 64'h120);
    check("rel_count", bus.bubble_count, 0);

    // ---- saturation: 0xFFFE flush bubbles, then three more ----
    @(negedge clk);
    bus.flush = 1'b1;
    repeat (65534) @(posedge clk);
    #1 check("sat_preload", bus.bubble_count, 16'hFFFE);
    for (int i = 0; i < 3; i++) begin
      edge_sample();
      check($sformatf("sat_%0d", i), bus.bubble_count, 16'hFFFF);
    end
    check("sat_valid", bus.ex_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
